// File: rtl/branch_predictor.sv
// IF-stage branch predictor: direct-mapped BTB with a 2-bit saturating counter per entry.
// Lookup is combinational on IFpc; training comes from the MEM-stage branch resolution.
module branch_predictor #(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IFpc,
    output logic        PRtaken,
    output logic [31:0] PRtarget,
    input  logic        MMupdate,
    input  logic [31:0] MMpc,
    input  logic        MMtaken,
    input  logic [31:0] MMtarget
);

    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic [IDX_W-1:0] mm_idx;
    logic [TAG_W-1:0] mm_tag;
    logic             mm_hit;
    logic [1:0]       ctr_nxt;

    // Word-offset bits carry no information for a word-aligned fetch stream.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IFpc[1:0], MMpc[1:0]};

    assign if_idx = IFpc[IDX_W+1:2];
    assign if_tag = IFpc[31:IDX_W+2];
    assign mm_idx = MMpc[IDX_W+1:2];
    assign mm_tag = MMpc[31:IDX_W+2];

    assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign PRtaken  = if_hit && ctr_q[if_idx][1];
    assign PRtarget = PRtaken ? tgt_q[if_idx] : 32'h0;

    assign mm_hit = valid_q[mm_idx] && (tag_q[mm_idx] == mm_tag);

    always_comb begin
        ctr_nxt = ctr_q[mm_idx];
        if (!mm_hit) begin
            ctr_nxt = MMtaken ? 2'b10 : 2'b01;
        end else if (MMtaken && (ctr_q[mm_idx] != 2'b11)) begin
            ctr_nxt = ctr_q[mm_idx] + 2'd1;
        end else if (!MMtaken && (ctr_q[mm_idx] != 2'b00)) begin
            ctr_nxt = ctr_q[mm_idx] - 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
                tgt_q[i]   <= 32'h0;
            end
        end else if (MMupdate) begin
            valid_q[mm_idx] <= 1'b1;
            tag_q[mm_idx]   <= mm_tag;
            ctr_q[mm_idx]   <= ctr_nxt;
            // A not-taken hit keeps the last known target; a not-taken allocate clears it.
            if (MMtaken) begin
                tgt_q[mm_idx] <= MMtarget;
            end else if (!mm_hit) begin
                tgt_q[mm_idx] <= 32'h0;
            end
        end
    end

endmodule
